// File: rtl/sid_spi_writer.sv
// rtl/sid_spi_writer.sv - SPI mode-0 writer for 24-bit SID register frames
// Frame = {1, 4'b0, addr[2:0], data[15:0]}, MSB first; all SPI pins come straight from flops.
module sid_spi_writer #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_data,
  output logic        busy,
  output logic        done,
  output logic        spi_clk,
  output logic        spi_cs_n,
  output logic        spi_mosi
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] frame_q, frame_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        done_q, done_d;
  logic        phase_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= 8'd0;
      bit_q   <= 5'd0;
      frame_q <= 24'd0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
    end
  end

  // The GAP state reuses the phase counter with its own terminal count.
  assign phase_end = (phase_q == ((state_q == GAP) ? GAP_LAST : HP_LAST));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 8'd1;
    bit_d   = bit_q;
    frame_d = frame_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = 8'd0;
        if (req_valid) begin
          state_d = SETUP;
          frame_d = {1'b1, 4'b0000, req_addr, req_data};
          bit_d   = 5'd0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
        end
      end
      SETUP, SHIFT_LO: begin
        if (phase_end) begin
          phase_d = 8'd0;
          sclk_d  = 1'b1;
          state_d = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        // Shifting on the falling edge keeps mosi stable across the next full high phase;
        // after 24 shifts the register is empty, so mosi is 0 through HOLD and GAP.
        if (phase_end) begin
          phase_d = 8'd0;
          sclk_d  = 1'b0;
          frame_d = {frame_q[22:0], 1'b0};
          bit_d   = bit_q + 5'd1;
          state_d = (bit_q == 5'd23) ? HOLD : SHIFT_LO;
        end
      end
      HOLD: begin
        if (phase_end) begin
          phase_d = 8'd0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (phase_end) begin
          phase_d = 8'd0;
          state_d = IDLE;
        end
      end
      default: begin
        phase_d = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign spi_clk   = sclk_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = frame_q[23];

endmodule

// File: tb/tb_sid_spi_writer.sv
// tb/tb_sid_spi_writer.sv - scoreboard bench for sid_spi_writer
// Two instances (default timing and HALF_PERIOD=3/CS_GAP=1) share one clock and one stimulus plan.
module tb_sid_spi_writer;

  typedef struct {
    logic [23:0] frame;
    int          t0;
    int          gap;
  } exp_t;

  logic clk = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input int inst, input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL [%0d] %s: got 0x%0h want 0x%0h", inst, name, act, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int HP  = (g == 0) ? 4 : 3;
    localparam int GP  = (g == 0) ? 4 : 1;
    localparam logic [15:0] D0 = (g == 0) ? 16'h1234 : 16'hAAAA;
    localparam logic [15:0] D1 = (g == 0) ? 16'h00A5 : 16'h5555;

    logic        rst_n, req_valid, req_ready, busy, done, spi_clk, spi_cs_n, spi_mosi;
    logic [2:0]  req_addr;
    logic [15:0] req_data;
    int          cyc = 0;
    bit          fin = 0;
    bit          prev_hold = 0;
    exp_t        exp_q[$];
    logic [15:0] regs[5];
    logic [15:0] ref_regs[5];

    sid_spi_writer #(.HALF_PERIOD(HP), .CS_GAP(GP)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
      .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SID slave: shifts on spi_clk rise, commits on cs_n rise after exactly 24 bits.
    logic [23:0] sl_sh = 24'd0;
    int          sl_n = 0;
    initial for (int i = 0; i < 5; i++) begin
      regs[i]     = 16'h0F00 + 16'(i);
      ref_regs[i] = 16'h0F00 + 16'(i);
    end
    always @(posedge spi_clk) if (!spi_cs_n) begin
      sl_sh = {sl_sh[22:0], spi_mosi};
      sl_n++;
    end
    always @(negedge spi_cs_n) sl_n = 0;
    always @(posedge spi_cs_n) begin
      if (sl_n == 24 && sl_sh[23] && sl_sh[18:16] < 3'd5)
        regs[sl_sh[18:16]] = (sl_sh[18:16] < 3'd2) ? sl_sh[15:0] : {8'h00, sl_sh[7:0]};
      sl_n = 0;
    end

    // Monitor: rebuilds each frame from the pins and compares against the scoreboard entry.
    exp_t        cur;
    logic [23:0] bits;
    int rises, low_run, hi_run, run, last_t0;
    int phase_err, mosi_err, rise_err, idle_err;
    bit in_frame, have_rise, wait_ready;
    logic prev_clk, prev_cs, prev_mosi;

    always @(negedge clk) begin
      if (!rst_n) begin
        bits = 0; rises = 0; low_run = 0; hi_run = 0; run = 0;
        phase_err = 0; mosi_err = 0; rise_err = 0;
        in_frame = 0; have_rise = 0; wait_ready = 0;
        prev_clk = 0; prev_cs = 1; prev_mosi = 0;
      end else begin
        if (prev_cs && !spi_cs_n) begin
          bits = 0; rises = 0; low_run = 0;
          phase_err = 0; mosi_err = 0; rise_err = 0;
          if (exp_q.size() == 0) begin
            chk(g, "unexpected_frame", 1, 0);
          end else begin
            cur = exp_q[0];
            in_frame = 1;
            chk(g, "cs_fall_time", cyc - cur.t0 + 1, 1);
            if (cur.gap >= 0 && have_rise) chk(g, "cs_gap", hi_run, cur.gap);
          end
        end
        if (!spi_cs_n) begin
          low_run++;
          if (prev_cs) run = 1;
          else if (spi_clk != prev_clk) begin
            if (run != HP) phase_err++;
            run = 1;
          end else run++;
          if (spi_clk && !prev_clk) begin
            bits = {bits[22:0], spi_mosi};
            if (cyc - cur.t0 + 1 != 1 + HP + 2 * HP * rises) rise_err++;
            rises++;
          end
          if (!prev_cs && spi_mosi != prev_mosi && !(prev_clk && !spi_clk)) mosi_err++;
        end else begin
          if (spi_mosi || spi_clk) idle_err++;
          hi_run = prev_cs ? hi_run + 1 : 1;
        end
        if (done) begin
          if (!in_frame) chk(g, "unexpected_done", 1, 0);
          else begin
            chk(g, "frame", bits, cur.frame);
            chk(g, "rises", rises, 24);
            chk(g, "done_time", cyc - cur.t0 + 1, 1 + 49 * HP);
            chk(g, "cs_low_len", low_run, 49 * HP);
            chk(g, "hold_len", run, HP);
            chk(g, "phase_err", phase_err, 0);
            chk(g, "mosi_change_err", mosi_err, 0);
            chk(g, "rise_time_err", rise_err, 0);
            last_t0 = cur.t0;
            void'(exp_q.pop_front());
            in_frame = 0;
            have_rise = 1;
            wait_ready = 1;
          end
        end
        if (wait_ready && req_ready) begin
          chk(g, "ready_time", cyc - last_t0 + 1, 1 + 49 * HP + GP);
          chk(g, "idle_pins_err", idle_err, 0);
          wait_ready = 0;
        end
        prev_clk = spi_clk; prev_cs = spi_cs_n; prev_mosi = spi_mosi;
      end
    end

    task automatic send(input logic [2:0] a, input logic [15:0] d, input bit hold, input bit upd);
      exp_t e;
      int   w;
      req_addr = a; req_data = d; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 3000) begin
        @(negedge clk);
        w++;
      end
      chk(g, "accept_timeout", req_ready, 1);
      if (req_ready) begin
        e.frame = {1'b1, 4'b0000, a, d};
        e.t0    = cyc + 1;
        e.gap   = prev_hold ? GP + 1 : -1;
        exp_q.push_back(e);
        if (upd && a < 3'd5) ref_regs[a] = (a < 3'd2) ? d : {8'h00, d[7:0]};
      end
      @(posedge clk);
      #1;
      req_addr = 3'($urandom);
      req_data = 16'($urandom);
      if (!hold) req_valid = 1'b0;
      prev_hold = hold;
      @(negedge clk);
    endtask

    task automatic drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || !req_ready) && w < 5000) begin
        @(negedge clk);
        w++;
      end
      chk(g, "drain_timeout", w < 5000, 1);
    endtask

    task automatic check_regs();
      for (int i = 0; i < 5; i++) chk(g, $sformatf("slave_reg%0d", i), regs[i], ref_regs[i]);
    endtask

    task automatic check_idle_pins(input string tag);
      chk(g, {tag, "_cs_n"}, spi_cs_n, 1);
      chk(g, {tag, "_spi_clk"}, spi_clk, 0);
      chk(g, {tag, "_mosi"}, spi_mosi, 0);
      chk(g, {tag, "_done"}, done, 0);
      chk(g, {tag, "_busy"}, busy, 0);
    endtask

    initial begin
      int   r, w;
      bit   h;
      logic p;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = 3'd0; req_data = 16'd0;
      repeat (3) @(negedge clk);
      #1 check_idle_pins("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk(g, "ready_after_reset", req_ready, 1);

      send(3'd0, D0, 0, 1);
      drain();
      send(3'd4, D1, 0, 1);
      drain();
      check_regs();

      for (int i = 0; i < 3; i++) send(3'($urandom), 16'($urandom), i < 2, 1);
      drain();

      // Abort a frame at its 10th spi_clk rise.
      send(3'd1, 16'hFFFF, 0, 0);
      r = 0; w = 0; p = spi_clk;
      while (r < 10 && w < 3000) begin
        @(negedge clk);
        if (spi_clk && !p) r++;
        p = spi_clk;
        w++;
      end
      chk(g, "abort_rise_timeout", r, 10);
      #2 rst_n = 1'b0;
      #1 check_idle_pins("abort");
      exp_q.delete();
      prev_hold = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk(g, "ready_after_abort", req_ready, 1);
      send(3'd1, 16'h0001, 0, 1);
      drain();

      h = 0;
      for (int i = 0; i < 8; i++) begin
        if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
        h = (i < 7) ? 1'($urandom) : 1'b0;
        send(3'($urandom), 16'($urandom), h, 1);
      end
      drain();
      check_regs();
      fin = 1;
    end
  end

  initial begin
    int w;
    w = 0;
    while (!(u[0].fin && u[1].fin) && w < 60000) begin
      @(posedge clk);
      w++;
    end
    if (w >= 60000) begin
      bad++;
      total++;
      $display("FAIL global_timeout: got %0d cycles want fewer than 60000", w);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
